fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage and IF/ID pipeline register for the pipelined MIPS core. It owns the PC and issues word fetches to instruction memory over a request/response handshake. It holds the fetched instruction and PC+4 for the decode stage, whose opcode field `instr_d[31:26]` drives the main decoder. It applies branch and jump redirects from decode and stalls from the hazard unit, and discards any fetch that a redirect makes stale.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `imem_req`  out  1  fetch request valid.
- `imem_addr`  out  32  word-aligned fetch address; bits [1:0] are always 0.
- `imem_ready`  in  1  memory accepts the request this cycle.
- `imem_rvalid`  in  1  response valid; exactly one per accepted request, at least 1 cycle after acceptance, in order.
- `imem_rdata`  in  32  fetched instruction.
- `stall_d`  in  1  decode cannot consume; the IF/ID contents must hold.
- `pcsrc_d`  in  1  taken branch (beq/bne) resolved in decode.
- `pcbranch_d`  in  32  branch target.
- `jump_d`  in  1  main decoder jump for the instruction in IF/ID.
- `instr_d`  out  32  IF/ID instruction; reset value 32'h0000_0000 (nop).
- `pcplus4_d`  out  32  IF/ID fetch address + 4; reset value 0.
- `valid_d`  out  1  IF/ID holds a live instruction; reset value 0.
- `pc_f`  out  32  current fetch PC; reset value `RESET_PC`.

## Operation
- **Redirect.**
  - Redirect is `(jump_d | pcsrc_d) & valid_d`. It is ignored while `valid_d`=0.
  - Jump target is `{pcplus4_d[31:28], instr_d[25:0], 2'b00}`. Jump has priority over branch.
  - Redirect overrides `stall_d`: a redirect and a stall in the same cycle resolve as a redirect.
- **Handshake.**
  - A request is accepted when `imem_req & imem_ready`.
  - At most one request is outstanding.
  - `imem_addr` = `pc_f`. It stays stable while unaccepted, unless a redirect changes `pc_f`.
  - On acceptance, `pc_f` <= `pc_f`+4, wrapping modulo 2^32.
- **FSM states.**
  - IDLE: no request outstanding.
  - WAIT: one request outstanding, response wanted.
  - KILL: one request outstanding, response to be discarded.
- **FSM transitions.**
  - IDLE --accept--> WAIT.
  - WAIT --redirect, no rvalid--> KILL.
  - WAIT --rvalid, no new accept--> IDLE.
  - WAIT --rvalid & accept--> WAIT.
  - KILL --rvalid--> IDLE. The response is dropped; IF/ID and the buffer are untouched.
- **One-entry skid buffer.**
  - Holds the instruction and PC+4 of a response that arrives while `stall_d`=1 and `valid_d`=1.
  - When `stall_d` drops, the buffer moves into IF/ID and empties.
- **Request issue condition.** `imem_req`=1 when all of the following hold:
  - reset is inactive;
  - the buffer is empty, or is draining this cycle;
  - the state is IDLE, or the state is WAIT with `imem_rvalid`=1 and the response going straight into IF/ID.
- **IF/ID load priority.**
  - Reset.
  - Redirect: `valid_d` <= 0, the buffer is cleared, `pc_f` <= target, and WAIT becomes KILL. If the response arrives in that same cycle, the response is dropped and the state goes to IDLE.
  - `stall_d`: hold.
  - Buffer: load from the buffer.
  - `imem_rvalid` in WAIT: load the response.
  - Otherwise: `valid_d` <= 0 (bubble).
- **PC+4 capture.** The address of each accepted request is tracked so that `pcplus4_d` = that address + 4.
- **Reset mid-operation.** Any outstanding response is forgotten; the state is IDLE. The memory side must also be reset.

## Timing
- Reset (`reset`=0 at an edge) sets:
  - `pc_f`=`RESET_PC`, `imem_req`=0, `valid_d`=0, `instr_d`=0, `pcplus4_d`=0;
  - buffer empty, state IDLE.
- First `imem_req` is asserted in the first cycle after `reset` returns high.
- Zero-wait memory (`imem_ready`=1, `imem_rvalid` the cycle after acceptance):
  - fetch throughput is one instruction per cycle;
  - address-to-`instr_d` latency is 2 edges.
- Redirect seen in cycle N:
  - `pc_f`=target after edge N;
  - the target request is issued in cycle N+1 if the state is IDLE. If the state is KILL, it is issued once the stale response returns.
  - `valid_d`=0 after edge N, so at least one bubble follows.

## Test plan
- Reset with `RESET_PC`=32'h0000_0040 and zero-wait memory:
  - `imem_addr` sequence is 0x40, 0x44, 0x48;
  - `instr_d` follows one cycle behind;
  - `pcplus4_d` = 0x44, 0x48, 0x4C.
- `imem_ready` low for 3 cycles: `imem_addr` holds 0x44, and `pc_f` does not advance until acceptance.
- `stall_d` for 4 cycles while a response arrives: `instr_d` holds, the buffer captures the response, and the buffered instruction appears on the first edge after the stall ends. No instruction is lost or duplicated.
- Jump with `instr_d`=32'h0800_0100 and `pcplus4_d`=32'h0000_0008:
  - next `imem_addr` = 32'h0000_0400;
  - a response in flight during the redirect is discarded.
- `pcsrc_d`=1 with `pcbranch_d`=0x80 while `rvalid` is delayed 3 cycles: state goes to KILL, the late response is dropped, the 0x80 fetch follows, and `valid_d` stays 0 in between.
- Jump and branch together with `stall_d`=1: the jump target wins, and the redirect overrides the stall.
- `reset` asserted while a request is outstanding: all outputs return to their reset values on the next edge.

Source files
------------

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and instruction memory.
interface fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC, single-outstanding imem handshake, IF/ID register
// with a one-entry skid buffer, and redirect handling that discards stale fetches.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 reset,
    fetch_stage_if.master        imem,
    input  logic                 stall_d,
    input  logic                 pcsrc_d,
    input  logic [31:0]          pcbranch_d,
    input  logic                 jump_d,
    output logic [31:0]          instr_d,
    output logic [31:0]          pcplus4_d,
    output logic                 valid_d,
    output logic [31:0]          pc_f
);

    typedef enum logic [1:0] {IDLE, WAIT, KILL} state_t;

    state_t      state, state_next;
    logic        redirect, hold, resp_ok, drain, accept, req;
    logic [31:0] target;
    logic        buf_vld;
    logic [31:0] buf_instr, buf_pc4;
    logic [31:0] req_addr;

    // A stall only has meaning while IF/ID holds a live instruction.
    always_comb begin
        redirect = (jump_d | pcsrc_d) & valid_d;
        target   = jump_d ? {pcplus4_d[31:28], instr_d[25:0], 2'b00} : pcbranch_d;
        hold     = stall_d & valid_d;
        resp_ok  = (state == WAIT) & imem.imem_rvalid & ~redirect;
        drain    = buf_vld & ~hold & ~redirect;
        req      = reset & ~redirect & (~buf_vld | drain) &
                   ((state == IDLE) | (resp_ok & ~hold & ~buf_vld));
        accept   = req & imem.imem_ready;
    end

    assign imem.imem_req  = req;
    assign imem.imem_addr = {pc_f[31:2], 2'b00};

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = WAIT;
            WAIT: begin
                if (imem.imem_rvalid)
                    state_next = accept ? WAIT : IDLE;
                else if (redirect)
                    state_next = KILL;
            end
            KILL: if (imem.imem_rvalid) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            pc_f      <= RESET_PC;
            valid_d   <= 1'b0;
            instr_d   <= 32'h0000_0000;
            pcplus4_d <= 32'h0000_0000;
            buf_vld   <= 1'b0;
        end else begin
            state <= state_next;
            if (redirect)
                pc_f <= target;
            else if (accept)
                pc_f <= pc_f + 32'd4;

            // IF/ID priority: redirect, stall, skid buffer, fresh response, bubble.
            if (redirect) begin
                valid_d <= 1'b0;
                buf_vld <= 1'b0;
            end else if (hold) begin
                if (resp_ok)
                    buf_vld <= 1'b1;
            end else if (buf_vld) begin
                instr_d   <= buf_instr;
                pcplus4_d <= buf_pc4;
                valid_d   <= 1'b1;
                buf_vld   <= 1'b0;
            end else if (resp_ok) begin
                instr_d   <= imem.imem_rdata;
                pcplus4_d <= req_addr + 32'd4;
                valid_d   <= 1'b1;
            end else begin
                valid_d <= 1'b0;
            end
        end
    end

    // Data-only registers; their validity is tracked by the FSM and buf_vld.
    always_ff @(posedge clk) begin
        if (accept)
            req_addr <= imem.imem_addr;
        if (resp_ok & hold) begin
            buf_instr <= imem.imem_rdata;
            buf_pc4   <= req_addr + 32'd4;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus randomized memory/stall/redirect traffic
// checked against a program-order model of the instruction stream.
module tb_fetch_stage;
    localparam logic [31:0] RPC = 32'h0000_0040;

    logic        clk = 1'b0;
    logic        reset, stall_d, pcsrc_d, jump_d, valid_d;
    logic [31:0] pcbranch_d, instr_d, pcplus4_d, pc_f;

    int          tests = 0;
    int          fails = 0;
    bit          pend;
    logic [31:0] pend_addr;
    int          pend_wait;
    int          lat;
    bit          rnd_lat;
    bit          s_req, s_acc;
    logic [31:0] s_addr;
    logic [31:0] exp_pc;
    int          retired, idle_cnt;
    bit          prev_unacc, prev_redir;
    logic [31:0] prev_addr;
    logic [31:0] hpc, tgt, tmp, p4;
    int          n, r0;

    always #5 clk = ~clk;

    fetch_stage_if bus();

    fetch_stage #(.RESET_PC(RPC)) dut (
        .clk(clk), .reset(reset), .imem(bus),
        .stall_d(stall_d), .pcsrc_d(pcsrc_d), .pcbranch_d(pcbranch_d), .jump_d(jump_d),
        .instr_d(instr_d), .pcplus4_d(pcplus4_d), .valid_d(valid_d), .pc_f(pc_f)
    );

    function automatic logic [31:0] memf(input logic [31:0] a);
        if (a == 32'h0000_0004) return 32'h0800_0100;
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // One clock cycle: drive memory response, sample, score, advance to next negedge.
    task automatic cyc();
        bit          redir;
        logic [31:0] ins, pp4;
        bus.imem_rvalid = pend && (pend_wait == 0);
        bus.imem_rdata  = bus.imem_rvalid ? memf(pend_addr) : 32'hBAD0_BAD0;
        #1;
        s_req = bus.imem_req;
        s_addr = bus.imem_addr;
        s_acc = s_req & bus.imem_ready;
        redir = (jump_d | pcsrc_d) & valid_d;
        if (s_req) check("addr_align", {30'b0, s_addr[1:0]}, 32'd0);
        if (s_acc) check("one_outstanding", {31'b0, pend & ~bus.imem_rvalid}, 32'd0);
        if (reset && prev_unacc && !prev_redir && s_req) check("addr_stable", s_addr, prev_addr);
        if (reset && valid_d && (redir || !stall_d)) begin
            ins = memf(exp_pc);
            pp4 = exp_pc + 32'd4;
            check("sb_pcplus4", pcplus4_d, pp4);
            check("sb_instr", instr_d, ins);
            if (redir) exp_pc = jump_d ? {pp4[31:28], ins[25:0], 2'b00} : pcbranch_d;
            else       exp_pc = pp4;
            retired++;
            idle_cnt = 0;
        end else begin
            idle_cnt++;
        end
        if (reset && idle_cnt > 60) begin
            check("progress_timeout", idle_cnt, 32'd0);
            idle_cnt = 0;
        end
        prev_unacc = s_req & ~s_acc;
        prev_addr  = s_addr;
        prev_redir = redir;
        @(posedge clk);
        if (!reset) begin
            pend = 1'b0;
        end else begin
            if (bus.imem_rvalid) pend = 1'b0;
            else if (pend && pend_wait > 0) pend_wait--;
            if (s_acc) begin
                pend = 1'b1;
                pend_addr = s_addr;
                pend_wait = rnd_lat ? int'($urandom_range(0, 3)) : lat;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b0; stall_d = 1'b0; pcsrc_d = 1'b0; jump_d = 1'b0;
        bus.imem_ready = 1'b1;
        cyc();
        cyc();
        reset = 1'b1;
        exp_pc = RPC;
        idle_cnt = 0;
        prev_unacc = 1'b0;
    endtask

    initial begin
        reset = 1'b0; stall_d = 1'b0; pcsrc_d = 1'b0; jump_d = 1'b0; pcbranch_d = 32'h0;
        bus.imem_ready = 1'b1; bus.imem_rvalid = 1'b0; bus.imem_rdata = 32'h0;
        pend = 1'b0; pend_addr = 32'h0; pend_wait = 0; lat = 0; rnd_lat = 1'b0;
        exp_pc = RPC; retired = 0; idle_cnt = 0;
        prev_unacc = 1'b0; prev_redir = 1'b0; prev_addr = 32'h0;
        @(negedge clk);

        // Reset values and zero-wait streaming from RESET_PC.
        do_reset();
        check("rst_pc_f", pc_f, RPC);
        check("rst_valid_d", valid_d, 32'd0);
        check("rst_instr_d", instr_d, 32'd0);
        check("rst_pcplus4_d", pcplus4_d, 32'd0);
        check("rst_imem_req", s_req, 32'd0);
        cyc();
        check("first_req", s_req, 32'd1);
        check("addr_0", s_addr, 32'h40);
        cyc();
        check("addr_1", s_addr, 32'h44);
        check("instr_0", instr_d, memf(32'h40));
        check("pc4_0", pcplus4_d, 32'h44);
        cyc();
        check("addr_2", s_addr, 32'h48);
        check("instr_1", instr_d, memf(32'h44));
        check("pc4_1", pcplus4_d, 32'h48);
        cyc();
        check("pc4_2", pcplus4_d, 32'h4C);
        check("instr_2", instr_d, memf(32'h48));

        // imem_ready low for three cycles on the second fetch.
        do_reset();
        cyc();
        bus.imem_ready = 1'b0;
        repeat (3) begin
            cyc();
            check("nrdy_addr", s_addr, 32'h44);
            check("nrdy_pc_f", pc_f, 32'h44);
        end
        bus.imem_ready = 1'b1;
        cyc();
        check("rdy_addr", s_addr, 32'h44);
        check("rdy_pc_f", pc_f, 32'h48);

        // Stall for four cycles while a response lands in the skid buffer.
        repeat (4) cyc();
        check("stall_pre_valid", valid_d, 32'd1);
        hpc = exp_pc;
        stall_d = 1'b1;
        repeat (4) begin
            cyc();
            check("stall_hold_instr", instr_d, memf(hpc));
            check("stall_hold_pc4", pcplus4_d, hpc + 32'd4);
            check("stall_no_req", s_req, 32'd0);
        end
        stall_d = 1'b0;
        cyc();
        check("skid_instr", instr_d, memf(hpc + 32'd4));
        check("skid_pc4", pcplus4_d, hpc + 32'd8);
        cyc();
        check("after_skid_pc4", pcplus4_d, hpc + 32'd12);
        check("after_skid_valid", valid_d, 32'd1);

        // Branch to 4, then jump from the 0x0800_0100 at address 4.
        pcsrc_d = 1'b1; pcbranch_d = 32'h4;
        cyc();
        pcsrc_d = 1'b0;
        check("br4_pc_f", pc_f, 32'h4);
        check("br4_bubble", valid_d, 32'd0);
        n = 0;
        while (!(valid_d && pcplus4_d == 32'h8) && n < 10) begin cyc(); n++; end
        check("j_src_pc4", pcplus4_d, 32'h8);
        check("j_src_instr", instr_d, 32'h0800_0100);
        jump_d = 1'b1;
        cyc();
        jump_d = 1'b0;
        check("j_pc_f", pc_f, 32'h400);
        check("j_bubble", valid_d, 32'd0);
        cyc();
        check("j_req", s_req, 32'd1);
        check("j_addr", s_addr, 32'h400);
        cyc();
        check("j_instr", instr_d, memf(32'h400));
        check("j_pc4", pcplus4_d, 32'h404);

        // Branch while the response is delayed: stale response dropped in KILL.
        lat = 3;
        repeat (8) cyc();
        n = 0;
        while (!valid_d && n < 10) begin cyc(); n++; end
        check("k_pre_valid", valid_d, 32'd1);
        pcsrc_d = 1'b1; pcbranch_d = 32'h80;
        cyc();
        pcsrc_d = 1'b0;
        check("k_pc_f", pc_f, 32'h80);
        n = 0;
        do begin
            cyc();
            check("k_bubble", valid_d, 32'd0);
            n++;
        end while (!s_req && n < 12);
        check("k_req_addr", s_addr, 32'h80);
        n = 0;
        while (!valid_d && n < 12) begin cyc(); n++; end
        check("k_instr", instr_d, memf(32'h80));
        check("k_pc4", pcplus4_d, 32'h84);

        // Jump and branch together under stall: jump target wins.
        lat = 0;
        repeat (6) cyc();
        check("jb_pre_valid", valid_d, 32'd1);
        tmp = memf(exp_pc);
        p4  = exp_pc + 32'd4;
        tgt = {p4[31:28], tmp[25:0], 2'b00};
        stall_d = 1'b1; jump_d = 1'b1; pcsrc_d = 1'b1; pcbranch_d = 32'h200;
        cyc();
        stall_d = 1'b0; jump_d = 1'b0; pcsrc_d = 1'b0;
        check("jb_pc_f", pc_f, tgt);
        check("jb_bubble", valid_d, 32'd0);
        cyc();
        check("jb_addr", s_addr, tgt);

        // Reset while a request is outstanding.
        lat = 3;
        n = 0;
        do begin cyc(); n++; end while (!s_acc && n < 10);
        reset = 1'b0;
        cyc();
        check("mid_rst_req", s_req, 32'd0);
        check("mid_rst_pc_f", pc_f, RPC);
        check("mid_rst_valid", valid_d, 32'd0);
        check("mid_rst_instr", instr_d, 32'd0);
        check("mid_rst_pc4", pcplus4_d, 32'd0);
        reset = 1'b1;
        exp_pc = RPC; idle_cnt = 0; prev_unacc = 1'b0;
        cyc();
        check("mid_rst_addr", s_addr, RPC);
        check("mid_rst_req1", s_req, 32'd1);

        // Randomized traffic against the program-order model.
        rnd_lat = 1'b1;
        r0 = retired;
        for (int i = 0; i < 3000; i++) begin
            bus.imem_ready = ($urandom % 10) < 7;
            stall_d        = ($urandom % 10) < 2;
            pcsrc_d        = ($urandom % 20) == 0;
            jump_d         = ($urandom % 30) == 0;
            pcbranch_d     = $urandom & 32'h0000_0FFC;
            cyc();
        end
        stall_d = 1'b0; pcsrc_d = 1'b0; jump_d = 1'b0; bus.imem_ready = 1'b1;
        check("rand_progress", {31'b0, (retired - r0) > 200}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
